// File: rtl/mm_dmem_ctrl.sv
// mm_dmem_ctrl: MEM-stage responder that turns the EX/MEM ld/st request into a held dcache handshake.
// Optional LL/SC link register when ATOMIC_LLSC_EN is defined.
module mm_dmem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef ATOMIC_LLSC_EN
  input  logic              ll,
  input  logic              sc,
`endif
  input  logic              dRENi,
  input  logic              dWENi,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] store,
  input  logic              halt,
  input  logic              ihit,
  input  logic              dmemready,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              dhit,
  output logic [DATA_W-1:0] loaddata,
  output logic              mstall,
  output logic              halt_out,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e            state_q, state_d;
  logic              ren_q, ren_d, wen_q, wen_d;
  logic              dhit_q, dhit_d, halt_q, halt_d, hpend_q, hpend_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d, load_q, load_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              reqValid, aligned;
`ifdef ATOMIC_LLSC_EN
  logic              linkV_q, linkV_d, sc_q, sc_d;
  logic [ADDR_W-1:0] linkA_q, linkA_d;
`endif

  // Once halt_out is up the stage accepts no further requests.
  assign reqValid = (dRENi | dWENi) & ~halt_q;
  assign aligned  = (ALUOut[1:0] == 2'b00);
  assign mstall   = (state_q == REQ) | ((state_q == IDLE) & reqValid & aligned);

  assign dmemREN   = ren_q;
  assign dmemWEN   = wen_q;
  assign dmemaddr  = addr_q;
  assign dmemstore = store_q;
  assign dhit      = dhit_q;
  assign loaddata  = load_q;
  assign halt_out  = halt_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    store_d = store_q;
    load_d  = load_q;
    dhit_d  = 1'b0;
    halt_d  = halt_q;
    hpend_d = hpend_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef ATOMIC_LLSC_EN
    linkV_d = linkV_q;
    linkA_d = linkA_q;
    sc_d    = sc_q;
`endif
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          hpend_d = halt;
          if (!aligned) begin
            state_d = DONE;
            dhit_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            addr_d  = ALUOut;
            store_d = store;
            wen_d   = dWENi;
            ren_d   = dRENi & ~dWENi;
            if (dRENi && dWENi) err_d = 1'b1;
`ifdef ATOMIC_LLSC_EN
            sc_d = 1'b0;
            if (dWENi && sc) begin
              linkV_d = 1'b0;
              if (linkV_q && (linkA_q == ALUOut)) begin
                sc_d = 1'b1;
              end else begin
                state_d = DONE;
                wen_d   = 1'b0;
                dhit_d  = 1'b1;
                load_d  = '0;
              end
            end else if (dRENi && !dWENi && ll) begin
              linkV_d = 1'b1;
              linkA_d = ALUOut;
            end
`endif
          end
        end else if (halt) begin
          halt_d = 1'b1;
        end
      end
      REQ: begin
        if (dmemready) begin
          state_d = DONE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          dhit_d  = 1'b1;
          cnt_d   = '0;
          if (ren_q) load_d = dmemload;
`ifdef ATOMIC_LLSC_EN
          if (wen_q && linkV_q && (linkA_q == addr_q)) linkV_d = 1'b0;
          if (sc_q) load_d = DATA_W'(1);
`endif
        end else if (cnt_q != MaxWait) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == MaxWait) err_d = 1'b1;
        end
      end
      DONE: begin
        if (hpend_q || halt) halt_d = 1'b1;
        // Leaving DONE needs a pipeline advance or a dropped request, so the op never reissues.
        if (ihit || !(dRENi || dWENi)) begin
          state_d = IDLE;
          hpend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      load_q  <= '0;
      dhit_q  <= 1'b0;
      halt_q  <= 1'b0;
      hpend_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef ATOMIC_LLSC_EN
      linkV_q <= 1'b0;
      linkA_q <= '0;
      sc_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      load_q  <= load_d;
      dhit_q  <= dhit_d;
      halt_q  <= halt_d;
      hpend_q <= hpend_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef ATOMIC_LLSC_EN
      linkV_q <= linkV_d;
      linkA_q <= linkA_d;
      sc_q    <= sc_d;
`endif
    end
  end

endmodule

// File: tb/tb_mm_dmem_ctrl.sv
// tb_mm_dmem_ctrl: per-cycle vector table with a scoreboard queue, plus reset and watchdog sequences.
// Define ATOMIC_LLSC_EN to also exercise the LL/SC vectors.
module tb_mm_dmem_ctrl;

  logic        CLK = 1'b0;
  logic        RST, dRENi, dWENi, halt, ihit, dmemready;
  logic        ll, sc;
  logic [31:0] ALUOut, store, dmemload;
  logic        dmemREN, dmemWEN, dhit, mstall, halt_out, err;
  logic [31:0] dmemaddr, dmemstore, loaddata;

  int testsRun = 0;
  int failCount = 0;
  int vecIdx = 0;

  typedef struct {
    logic        rst, rd, wr, ll, sc, halt, ihit, rdy;
    logic [31:0] addr, sdata, rdata;
    logic        eMstall, eRen, eWen, eDhit, eHalt, eErr, chkLd;
    logic [31:0] eLd, eAddr, eStore;
    int          idx;
  } vec_t;

  vec_t tbl[$];
  vec_t expQ[$];

  mm_dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
    .CLK(CLK), .RST(RST),
`ifdef ATOMIC_LLSC_EN
    .ll(ll), .sc(sc),
`endif
    .dRENi(dRENi), .dWENi(dWENi), .ALUOut(ALUOut), .store(store), .halt(halt),
    .ihit(ihit), .dmemready(dmemready), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .loaddata(loaddata), .mstall(mstall), .halt_out(halt_out), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic rst, rd, wr, l, s, input logic [31:0] addr, sdata,
                      input logic hlt, ih, rdy, input logic [31:0] rdata,
                      input logic mst, eRen, eWen, eDhit, eHalt, eErr, chkLd,
                      input logic [31:0] eLd, input logic [31:0] eAddr = 0,
                      input logic [31:0] eStore = 0);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.ll = l; v.sc = s; v.addr = addr; v.sdata = sdata;
    v.halt = hlt; v.ihit = ih; v.rdy = rdy; v.rdata = rdata; v.eMstall = mst;
    v.eRen = eRen; v.eWen = eWen; v.eDhit = eDhit; v.eHalt = eHalt; v.eErr = eErr;
    v.chkLd = chkLd; v.eLd = eLd; v.eAddr = eAddr; v.eStore = eStore; v.idx = tbl.size();
    tbl.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expQ.size() == 0) begin
      checkVal("scoreboard.empty", 32'(expQ.size()), 32'd1);
      return;
    end
    e = expQ.pop_front();
    checkVal($sformatf("v%0d.ren", e.idx), 32'(dmemREN), 32'(e.eRen));
    checkVal($sformatf("v%0d.wen", e.idx), 32'(dmemWEN), 32'(e.eWen));
    checkVal($sformatf("v%0d.dhit", e.idx), 32'(dhit), 32'(e.eDhit));
    checkVal($sformatf("v%0d.halt_out", e.idx), 32'(halt_out), 32'(e.eHalt));
    checkVal($sformatf("v%0d.err", e.idx), 32'(err), 32'(e.eErr));
    if (e.chkLd) checkVal($sformatf("v%0d.loaddata", e.idx), loaddata, e.eLd);
    if (e.eRen || e.eWen) checkVal($sformatf("v%0d.addr", e.idx), dmemaddr, e.eAddr);
    if (e.eWen) checkVal($sformatf("v%0d.store", e.idx), dmemstore, e.eStore);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    RST = v.rst; dRENi = v.rd; dWENi = v.wr; ll = v.ll; sc = v.sc;
    ALUOut = v.addr; store = v.sdata; halt = v.halt; ihit = v.ihit;
    dmemready = v.rdy; dmemload = v.rdata;
    #1;
    checkVal($sformatf("v%0d.mstall", v.idx), 32'(mstall), 32'(v.eMstall));
    expQ.push_back(v);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  initial begin
    int waited;
    RST = 1'b1; dRENi = 0; dWENi = 0; ll = 0; sc = 0; halt = 0; ihit = 0; dmemready = 0;
    ALUOut = 0; store = 0; dmemload = 0;
    repeat (2) @(posedge CLK);
    #1;
    checkVal("reset.ren", 32'(dmemREN), 0);
    checkVal("reset.wen", 32'(dmemWEN), 0);
    checkVal("reset.dhit", 32'(dhit), 0);
    checkVal("reset.err", 32'(err), 0);
    checkVal("reset.halt_out", 32'(halt_out), 0);
    checkVal("reset.loaddata", loaddata, 0);
    checkVal("reset.addr", dmemaddr, 0);
    checkVal("reset.mstall", 32'(mstall), 0);

    // rst rd wr ll sc addr sdata | halt ihit rdy rdata | mst ren wen dhit halt err chkLd ld addr store
    // Load 0x100, ready three cycles after the request.
    addv(0,1,0,0,0,'h100,0, 0,0,0,0, 1, 1,0,0,0,0, 1,0,'h100);
    addv(0,1,0,0,0,'h100,0, 0,0,0,0, 1, 1,0,0,0,0, 1,0,'h100);
    addv(0,1,0,0,0,'h100,0, 0,0,0,0, 1, 1,0,0,0,0, 1,0,'h100);
    addv(0,1,0,0,0,'h100,0, 0,0,1,'hDEADBEEF, 1, 0,0,1,0,0, 1,'hDEADBEEF);
    addv(0,1,0,0,0,'h100,0, 0,1,0,0, 0, 0,0,0,0,0, 1,'hDEADBEEF);
    addv(0,0,0,0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0, 1,'hDEADBEEF);
    // Store 0x0C, ready with the first WEN, request held through DONE.
    addv(0,0,1,0,0,'h0C,'h1234, 0,0,0,0, 1, 0,1,0,0,0, 1,'hDEADBEEF,'h0C,'h1234);
    addv(0,0,1,0,0,'h0C,'h1234, 0,0,1,'h0BAD0BAD, 1, 0,0,1,0,0, 1,'hDEADBEEF);
    addv(0,0,1,0,0,'h0C,'h1234, 0,0,0,0, 0, 0,0,0,0,0, 1,'hDEADBEEF);
    addv(0,0,1,0,0,'h0C,'h1234, 0,0,0,0, 0, 0,0,0,0,0, 1,'hDEADBEEF);
    addv(0,0,1,0,0,'h0C,'h1234, 0,1,0,0, 0, 0,0,0,0,0, 1,'hDEADBEEF);
    addv(0,0,0,0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0, 1,'hDEADBEEF);
    // Misaligned load, then reset clears err.
    addv(0,1,0,0,0,'h102,0, 0,0,0,0, 0, 0,0,1,0,1, 0,0);
    addv(0,0,0,0,0,0,0, 0,0,0,0, 0, 0,0,0,0,1, 0,0);
    addv(1,0,0,0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0, 1,0);
    // Load and store together: store wins, err set.
    addv(0,1,1,0,0,'h20,'h55, 0,0,0,0, 1, 0,1,0,0,1, 1,0,'h20,'h55);
    addv(0,1,1,0,0,'h20,'h55, 0,0,1,'h1111, 1, 0,0,1,0,1, 1,0);
    addv(0,1,1,0,0,'h20,'h55, 0,1,0,0, 0, 0,0,0,0,1, 1,0);
    addv(1,0,0,0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0, 1,0);
    // Halt riding on a load: halt_out follows dhit, later requests are ignored.
    addv(0,1,0,0,0,'h200,0, 1,0,0,0, 1, 1,0,0,0,0, 1,0,'h200);
    addv(0,1,0,0,0,'h200,0, 1,0,1,'hCAFEF00D, 1, 0,0,1,0,0, 1,'hCAFEF00D);
    addv(0,1,0,0,0,'h200,0, 1,1,0,0, 0, 0,0,0,1,0, 1,'hCAFEF00D);
    addv(0,1,0,0,0,'h300,0, 1,0,0,0, 0, 0,0,0,1,0, 1,'hCAFEF00D);
    addv(0,1,0,0,0,'h300,0, 1,0,0,0, 0, 0,0,0,1,0, 1,'hCAFEF00D);
    addv(1,0,0,0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0, 1,0);
    // Halt with no op is sticky until reset.
    addv(0,0,0,0,0,0,0, 1,0,0,0, 0, 0,0,0,1,0, 1,0);
    addv(0,0,0,0,0,0,0, 0,0,0,0, 0, 0,0,0,1,0, 1,0);
    addv(0,1,0,0,0,'h104,0, 0,0,0,0, 0, 0,0,0,1,0, 1,0);
    addv(1,0,0,0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0, 1,0);
`ifdef ATOMIC_LLSC_EN
    addv(0,1,0,1,0,'h40,0, 0,0,0,0, 1, 1,0,0,0,0, 1,0,'h40);
    addv(0,1,0,1,0,'h40,0, 0,0,1,'h77, 1, 0,0,1,0,0, 1,'h77);
    addv(0,1,0,1,0,'h40,0, 0,1,0,0, 0, 0,0,0,0,0, 1,'h77);
    addv(0,0,1,0,1,'h40,'h99, 0,0,0,0, 1, 0,1,0,0,0, 1,'h77,'h40,'h99);
    addv(0,0,1,0,1,'h40,'h99, 0,0,1,0, 1, 0,0,1,0,0, 1,1);
    addv(0,0,1,0,1,'h40,'h99, 0,1,0,0, 0, 0,0,0,0,0, 1,1);
    addv(0,0,1,0,1,'h40,'h99, 0,0,0,0, 1, 0,0,1,0,0, 1,0);
    addv(0,0,1,0,1,'h40,'h99, 0,1,0,0, 0, 0,0,0,0,0, 1,0);
    addv(0,0,0,0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0, 1,0);
`endif

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);
    checkVal("scoreboard.drained", 32'(expQ.size()), 0);

    // Watchdog: the cache never answers, err must rise after exactly four REQ cycles.
    @(negedge CLK);
    RST = 0; dRENi = 1; dWENi = 0; ll = 0; sc = 0; halt = 0; ihit = 0; dmemready = 0;
    ALUOut = 'h80;
    @(posedge CLK);
    #1;
    checkVal("wd.ren_start", 32'(dmemREN), 1);
    checkVal("wd.err_start", 32'(err), 0);
    waited = 0;
    while (err !== 1'b1 && waited < 20) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    checkVal("wd.cycles", 32'(waited), 4);
    checkVal("wd.ren_held", 32'(dmemREN), 1);
    checkVal("wd.mstall", 32'(mstall), 1);
    @(negedge CLK);
    RST = 1; dRENi = 0;
    @(posedge CLK);
    #1;
    checkVal("wd.rst_ren", 32'(dmemREN), 0);
    checkVal("wd.rst_err", 32'(err), 0);
    checkVal("wd.rst_dhit", 32'(dhit), 0);
    @(negedge CLK);
    RST = 0; dmemready = 1;
    @(posedge CLK);
    #1;
    checkVal("wd.late_ready_dhit", 32'(dhit), 0);
    checkVal("wd.late_ready_ren", 32'(dmemREN), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
